// File: rtl/counter_pkg.sv
// Shared types for the up/down counter: press-tracking FSM states,
// step-direction encoding and timer sizing helper.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } press_state_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } step_dir_t;

    // Bits needed for a timer that counts 0 .. max(hold, repeat)-1, never less than one.
    function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
        int longest;
        longest = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/press_repeat.sv
// Button press tracker: turns held up/down levels into step requests,
// with an initial step, a hold delay, then periodic auto-repeat.
module press_repeat
    import counter_pkg::*;
#(
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      up,
    input  logic      down,
    input  logic      enable,
    output logic      step_req,
    output step_dir_t step_dir
);

    localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TW-1:0] HOLD_LAST   = (HOLD_CYCLES > 0) ? TW'(HOLD_CYCLES - 1) : '0;
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    press_state_t    state;
    press_state_t    state_next;
    logic [TW-1:0]   timer;
    logic [TW-1:0]   timer_next;
    step_dir_t       dir_latched;
    step_dir_t       dir_next;
    step_dir_t       dir_now;
    logic            press;

    // Pressing both buttons cancels out; direction follows the up button.
    assign press   = up ^ down;
    assign dir_now = up ? DIR_UP : DIR_DOWN;

    // Decide this cycle's step and the FSM/timer/direction updates; the step is
    // combinational so the count moves on the same edge that samples the press.
    always_comb begin
        state_next = state;
        timer_next = timer;
        dir_next   = dir_latched;
        step_req   = 1'b0;
        step_dir   = dir_now;
        case (state)
            IDLE: begin
                if (press && enable) begin
                    step_req   = 1'b1;
                    dir_next   = dir_now;
                    timer_next = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (!press || !enable) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (dir_now != dir_latched) begin
                    step_req   = 1'b1;
                    dir_next   = dir_now;
                    timer_next = '0;
                end else if (HOLD_CYCLES > 0) begin
                    if (timer == HOLD_LAST) begin
                        step_req   = 1'b1;
                        timer_next = '0;
                        state_next = REPEAT;
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (!press || !enable) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else if (dir_now != dir_latched) begin
                    step_req   = 1'b1;
                    dir_next   = dir_now;
                    timer_next = '0;
                    state_next = HOLD;
                end else if (timer == REPEAT_LAST) begin
                    step_req   = 1'b1;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    // Register FSM state, timer and latched direction; reset returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            dir_latched <= DIR_DOWN;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            dir_latched <= dir_next;
        end
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parameterised modulo up/down counter driven by held buttons with
// auto-repeat, optional saturation, and a clamped synchronous load.
module counter_updown_param
    import counter_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MOD           = 16,
    parameter int SATURATE      = 0,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             wrap,
    output logic             at_min,
    output logic             at_max
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("counter_updown_param: WIDTH must be in 2..16");
    end
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
        $error("counter_updown_param: MOD must be in 2..2**WIDTH");
    end
    if (SATURATE != 0 && SATURATE != 1) begin : g_bad_saturate
        $error("counter_updown_param: SATURATE must be 0 or 1");
    end
    if (HOLD_CYCLES < 0) begin : g_bad_hold
        $error("counter_updown_param: HOLD_CYCLES must be >= 0");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("counter_updown_param: REPEAT_CYCLES must be >= 1");
    end

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MOD);

    logic             step_req;
    step_dir_t        step_dir;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] count_next;
    logic             step_next;
    logic             wrap_next;

    press_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_press_repeat (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .enable   (enable),
        .step_req (step_req),
        .step_dir (step_dir)
    );

    // Out-of-range load values land on the top of the count range.
    assign load_clamped = ({1'b0, load_value} >= MOD_EXT) ? MAX_COUNT : load_value;

    // Next count: load wins over any step; steps wrap or stick at the limits.
    always_comb begin
        count_next = count;
        step_next  = 1'b0;
        wrap_next  = 1'b0;
        if (load) begin
            count_next = load_clamped;
        end else if (step_req) begin
            if (step_dir == DIR_UP) begin
                if (count == MAX_COUNT) begin
                    if (SATURATE == 0) begin
                        count_next = '0;
                        step_next  = 1'b1;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = count + 1'b1;
                    step_next  = 1'b1;
                end
            end else begin
                if (count == '0) begin
                    if (SATURATE == 0) begin
                        count_next = MAX_COUNT;
                        step_next  = 1'b1;
                        wrap_next  = 1'b1;
                    end
                end else begin
                    count_next = count - 1'b1;
                    step_next  = 1'b1;
                end
            end
        end
    end

    // Register the count and its step/wrap pulses together so they line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            step  <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            count <= count_next;
            step  <= step_next;
            wrap  <= wrap_next;
        end
    end

    assign at_min = (count == '0);
    assign at_max = (count == MAX_COUNT);

endmodule
